counter_4bit_checker: RTL
=========================

Name: counter_4bit_checker

Overview:
- Receive-side monitor for the 4-bit free-running counter: samples Qa..Qd plus ripple carry Rc every enabled clock.
- Locks onto a valid +1 mod-16 sequence, then flags sequence breaks and carry mismatches, counts errors and full wraps.
- Sits beside the counter in the board top and in benches as a self-checking consumer of the counter outputs.

Parameters:
- LOCK_LEN, 4, consecutive good steps required to enter LOCKED (legal 1..15).
- ERR_CNT_W, 8, width of saturating error counter.
- WRAP_CNT_W, 8, width of wrap counter (modulo, no saturation).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; inputs are ignored when low.
- Qa  input  1  count bit 0 (LSB).
- Qb  input  1  count bit 1.
- Qc  input  1  count bit 2.
- Qd  input  1  count bit 3 (MSB).
- Rc  input  1  ripple carry from counter; expected high iff count == 4'hF.
- locked  output  1  high while state == LOCKED.
- err_pulse  output  1  one-cycle pulse on any error detected while LOCKED.
- seq_err  output  1  one-cycle pulse: sequence break while LOCKED.
- rc_err  output  1  one-cycle pulse: Rc mismatch while LOCKED.
- err_cnt  output  ERR_CNT_W  saturating count of err_pulse events.
- wrap_cnt  output  WRAP_CNT_W  count of 15->0 transitions observed while LOCKED.
- state  output  2  00 IDLE, 01 SEARCH, 10 LOCKED.

Behaviour:
- Reset (async, rst_n low): state=IDLE, prev=0, good_run=0, all outputs 0. Takes effect immediately; mid-run reset discards lock and counters.
- cur = {Qd,Qc,Qb,Qa}. All logic updates only on rising clk with en=1; with en=0 all registers hold, pulses drop to 0.
- Good step: cur == (prev + 1) mod 16 (4'hF -> 4'h0 is good). Any other value is a bad step.
- IDLE: first enabled sample stores prev=cur -> SEARCH, good_run=0. No checks.
- SEARCH: good step -> good_run+1; when good_run reaches LOCK_LEN -> LOCKED, good_run cleared. Bad step -> good_run=0, stay SEARCH. No errors flagged, Rc ignored.
- LOCKED: bad step -> seq_err=1, err_pulse=1, state -> SEARCH, good_run=0, locked drops next cycle. Rc != (cur==4'hF) -> rc_err=1, err_pulse=1; state unchanged if step good.
- Both errors on same sample: seq_err and rc_err both 1, err_pulse 1, err_cnt +1 (once).
- err_cnt saturates at all-ones; never wraps.
- wrap_cnt +1 when LOCKED and good step with prev==4'hF, cur==4'h0; wraps modulo 2^WRAP_CNT_W. Not counted in the transition that enters LOCKED or in SEARCH.
- prev updated to cur on every enabled sample in every state.
- All outputs registered; latency 1 clk from sampling edge. Pulses last exactly one cycle.
- Unused state encoding 11 -> IDLE next enabled edge.

Optional Feature:
- Macro COUNTER_CHECK_HOLD_EN.
- Defined: cur == prev is a legal hold (counter paused): good_run, state, pulses unaffected, Rc still checked in LOCKED.
- Not defined: cur == prev is a bad step like any other.

Test Plan:
- Reset, en=1, feed 0,1,2,3,4 with correct Rc -> state SEARCH after 0, LOCKED (locked=1) after sample 4, err_cnt=0.
- Locked, feed ...,14,15,0,1 with Rc=1 only at 15 -> wrap_cnt 0->1, no pulses; 40 more steps -> wrap_cnt=3 total after 48 steps from lock point crossing 3 wraps.
- Locked at 6, feed 9 -> seq_err=1, err_pulse=1 for one cycle, err_cnt=1, state SEARCH, relock after 4 good steps from 9 (at 13).
- Locked, feed 15 with Rc=0 -> rc_err pulse, err_cnt+1, stays LOCKED; feed 7 with Rc=1 while locked at 4 -> seq_err and rc_err same cycle, err_cnt +1 only.
- Force 300 errors with ERR_CNT_W=8 -> err_cnt holds 255; drop rst_n mid-stream -> all outputs 0 immediately, state IDLE.
- en toggled 0 between samples 3 and 4 for 5 cycles -> no state change; with COUNTER_CHECK_HOLD_EN, repeat 5,5 while locked -> no error; without it -> seq_err pulse.

Source files
------------

// File: rtl/counter_4bit_checker.sv
// Receive-side monitor for a 4-bit free-running counter: locks onto a +1 mod-16
// sequence, then flags sequence/carry errors. Optional macro: COUNTER_CHECK_HOLD_EN.
module counter_4bit_checker #(
  parameter int unsigned LOCK_LEN   = 4,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  Qa,
  input  logic                  Qb,
  input  logic                  Qc,
  input  logic                  Qd,
  input  logic                  Rc,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  seq_err,
  output logic                  rc_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic [1:0]            state
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_LOCKED = 2'b10,
    ST_UNUSED = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        prev_q, prev_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic                    locked_q, locked_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    seq_err_q, seq_err_d;
  logic                    rc_err_q, rc_err_d;
  logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [WRAP_CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic [CNT_W-1:0]        cur_c;
  logic [CNT_W-1:0]        prev_inc_c;
  logic [RUN_W-1:0]        run_inc_c;
  logic                    step_good_c;
  logic                    hold_c;
  logic                    rc_exp_c;

  assign cur_c       = {Qd, Qc, Qb, Qa};
  assign prev_inc_c  = prev_q + CNT_W'(1);
  assign run_inc_c   = run_q + RUN_W'(1);
  assign step_good_c = (cur_c == prev_inc_c);
  assign rc_exp_c    = (cur_c == 4'hF);

`ifdef COUNTER_CHECK_HOLD_EN
  // A repeated value means the counter is paused, not broken.
  assign hold_c = (cur_c == prev_q);
`else
  assign hold_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      run_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      seq_err_q   <= 1'b0;
      rc_err_q    <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      seq_err_q   <= seq_err_d;
      rc_err_q    <= rc_err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    seq_err_d   = 1'b0;
    rc_err_d    = 1'b0;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;

    if (en) begin
      prev_d = cur_c;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEARCH;
          run_d   = '0;
        end
        ST_SEARCH: begin
          if (!hold_c) begin
            if (step_good_c) begin
              if (run_inc_c == RUN_W'(LOCK_LEN)) begin
                state_d = ST_LOCKED;
                run_d   = '0;
              end else begin
                run_d = run_inc_c;
              end
            end else begin
              run_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          seq_err_d = !step_good_c && !hold_c;
          rc_err_d  = (Rc != rc_exp_c);
          if (seq_err_d) begin
            state_d = ST_SEARCH;
            run_d   = '0;
          end
          if (step_good_c && (prev_q == 4'hF)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase

      // One count per erroneous sample, saturating at all-ones.
      err_pulse_d = seq_err_d || rc_err_d;
      if (err_pulse_d && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign seq_err   = seq_err_q;
  assign rc_err    = rc_err_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign state     = state_q;

endmodule
